// File: rtl/pc_gen.sv
// Fetch-address generator: holds the fetch PC, issues it over valid/ready, applies trap/redirect targets.
// Optional misaligned-redirect check is enabled by defining PC_GEN_MISALIGN_CHECK_EN.
module pc_gen #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(32'h8000_0000),
    parameter int unsigned       INSTR_BYTES  = 4,
    parameter int unsigned       CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             trap_valid_i,
    input  logic [XLEN-1:0]  trap_pc_i,
    output logic             fetch_valid_o,
    input  logic             fetch_ready_i,
    output logic [XLEN-1:0]  fetch_pc_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic             misalign_o,
    output logic [XLEN-1:0]  misalign_addr_o
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pend_v;
    logic              r_pend_trap;
    logic [XLEN-1:0]   r_pend_pc;
    logic              r_halt_pend;

    state_t            w_state_nxt;
    logic [XLEN-1:0]   w_pc_nxt;
    logic              w_valid_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_pend_v_nxt;
    logic              w_pend_trap_nxt;
    logic [XLEN-1:0]   w_pend_pc_nxt;
    logic              w_halt_pend_nxt;

    logic              w_fire;
    logic              w_hold;
    logic              w_mis;
    logic              w_redir_ok;
    logic              w_req;
    logic [XLEN-1:0]   w_tgt;

    assign w_fire = r_valid & fetch_ready_i;
    assign w_hold = r_valid & ~fetch_ready_i;

`ifdef PC_GEN_MISALIGN_CHECK_EN
    // Only a redirect that actually wins selection is checked; trap targets never are.
    assign w_mis = redirect_valid_i & ~trap_valid_i & (|(redirect_pc_i & LOW_MASK));
`else
    assign w_mis = 1'b0;
`endif

    assign w_redir_ok = redirect_valid_i & ~w_mis;
    assign w_req      = trap_valid_i | w_redir_ok;
    assign w_tgt      = (trap_valid_i ? trap_pc_i : redirect_pc_i) & ~LOW_MASK;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_valid_nxt     = r_valid;
        w_cnt_nxt       = r_cnt;
        w_pend_v_nxt    = r_pend_v;
        w_pend_trap_nxt = r_pend_trap;
        w_pend_pc_nxt   = r_pend_pc;
        w_halt_pend_nxt = r_halt_pend;

        case (r_state)
            S_BOOT: begin
                if (w_req) w_pc_nxt = w_tgt;
                w_valid_nxt = ~stall_i;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_hold) begin
                    // Request held: outputs frozen, new targets parked by class priority.
                    if (trap_valid_i) begin
                        w_pend_v_nxt    = 1'b1;
                        w_pend_trap_nxt = 1'b1;
                        w_pend_pc_nxt   = w_tgt;
                    end else if (w_redir_ok && !(r_pend_v && r_pend_trap)) begin
                        w_pend_v_nxt    = 1'b1;
                        w_pend_trap_nxt = 1'b0;
                        w_pend_pc_nxt   = w_tgt;
                    end
                    if (halt_i) w_halt_pend_nxt = 1'b1;
                end else begin
                    if (w_fire) w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_req)
                        w_pc_nxt = w_tgt;
                    else if (w_fire && r_pend_v)
                        w_pc_nxt = r_pend_pc;
                    else if (w_fire)
                        w_pc_nxt = r_pc + XLEN'(INSTR_BYTES);
                    w_pend_v_nxt    = 1'b0;
                    w_pend_trap_nxt = 1'b0;
                    w_halt_pend_nxt = 1'b0;
                    if (halt_i || r_halt_pend) begin
                        w_state_nxt = S_HALTED;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_valid_nxt = ~stall_i;
                    end
                end
            end
            S_HALTED: begin
                w_valid_nxt = 1'b0;
                if (w_req) begin
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_VECTOR;
            r_valid     <= 1'b0;
            r_cnt       <= '0;
            r_pend_v    <= 1'b0;
            r_pend_trap <= 1'b0;
            r_pend_pc   <= '0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_valid     <= w_valid_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend_v    <= w_pend_v_nxt;
            r_pend_trap <= w_pend_trap_nxt;
            r_pend_pc   <= w_pend_pc_nxt;
            r_halt_pend <= w_halt_pend_nxt;
        end
    end

`ifdef PC_GEN_MISALIGN_CHECK_EN
    logic            r_misalign;
    logic [XLEN-1:0] r_misalign_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign <= w_mis;
            if (w_mis) r_misalign_addr <= redirect_pc_i;
        end
    end

    assign misalign_o      = r_misalign;
    assign misalign_addr_o = r_misalign_addr;
`else
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = '0;
`endif

    assign fetch_valid_o = r_valid;
    assign fetch_pc_o    = r_pc;
    assign halted_o      = (r_state == S_HALTED);
    assign fetch_cnt_o   = r_cnt;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator; successor to the basic program counter register of the OBSIDYEN core.
- Holds the architectural fetch PC and issues it to instruction fetch over a valid/ready handshake.
- Applies branch/jump redirects and trap redirects with fixed priority, and supports hazard stall, halt and resume.
- Keeps a running count of accepted fetches; sits between the branch/trap logic and instruction memory.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VECTOR, 32'h8000_0000, PC value loaded at reset (XLEN bits).
- INSTR_BYTES, 4, sequential increment; legal values 2 or 4. ALIGN = log2(INSTR_BYTES).
- CNT_W, 32, fetch counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard stall; blocks issue of a new request.
- halt_i  in  1  halt request.
- redirect_valid_i  in  1  branch/jump taken.
- redirect_pc_i  in  XLEN  branch/jump target.
- trap_valid_i  in  1  trap/exception redirect.
- trap_pc_i  in  XLEN  trap vector target.
- fetch_valid_o  out  1  fetch request valid.
- fetch_ready_i  in  1  fetch side accepts request.
- fetch_pc_o  out  XLEN  fetch address.
- halted_o  out  1  block is in HALTED.
- fetch_cnt_o  out  CNT_W  number of accepted fetches.
- misalign_o  out  1  misaligned target detected (optional feature).
- misalign_addr_o  out  XLEN  offending target (optional feature).

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_ni. Reset values:
  - state=BOOT, pc=RESET_VECTOR, fetch_valid_o=0, halted_o=0;
  - fetch_cnt_o=0, pending redirect cleared, misalign_o=0, misalign_addr_o=0.
- fire = fetch_valid_o & fetch_ready_i. fetch_pc_o = pc register (no combinational path from the redirect inputs).
- Target sources: trap beats redirect in the same cycle. Target low ALIGN bits are forced to 0.
- State BOOT:
  - lasts one cycle after reset release, then goes to RUN;
  - fetch_valid_o=0;
  - any redirect or trap seen in BOOT is applied to pc.
- State RUN:
  - fetch_valid_o rises the cycle after stall_i=0 with no request outstanding.
  - While fetch_valid_o=1 and !fetch_ready_i, fetch_valid_o and fetch_pc_o hold stable regardless of stall_i, halt_i or redirects.
  - On fire, fetch_cnt_o increments, wrapping modulo 2^CNT_W.
- Next-pc rules in RUN:
  - Redirect/trap with no outstanding request, or in the same cycle as fire: pc <= target next cycle; the pending slot is cleared.
  - Redirect/trap while a request is outstanding and not fired: latch into the pending slot. A trap overwrites a pending redirect; a redirect never overwrites a pending trap; newer of equal class wins.
  - fire with pending valid: pc <= pending target, pending cleared.
  - fire with no pending: pc <= pc + INSTR_BYTES, wrapping modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000 for XLEN=32, INSTR_BYTES=4).
- fetch_valid_o after fire: stays 1 the next cycle unless stall_i or halt_i is asserted that cycle.
- Halt:
  - halt_i in RUN with no outstanding request: enter HALTED next cycle.
  - With an outstanding request: enter HALTED the cycle after fire.
- State HALTED:
  - fetch_valid_o=0, halted_o=1, pc frozen;
  - redirect or trap: pc <= target, go to RUN, halted_o=0 next cycle; halt_i is ignored in that cycle;
  - halt_i held with no redirect: stay HALTED.
- Reset mid-operation: immediate return to reset values. An outstanding request is abandoned; the fetch side must tolerate this.

Optional Feature:
- Macro: PC_GEN_MISALIGN_CHECK_EN.
- Defined:
  - a redirect/trap target with nonzero low ALIGN bits is not applied (or latched into the pending slot);
  - misalign_o pulses 1 for one cycle and misalign_addr_o captures the raw target; pc continues sequentially;
  - trap targets are never checked.
- Undefined: low bits are forced to 0 silently; misalign_o and misalign_addr_o are tied 0.

Test Plan:
- Reset release, fetch_ready_i=1, no stall -> cycle 0 valid=0; then fetch_pc_o 0x8000_0000, 0x8000_0004, 0x8000_0008; fetch_cnt_o=3 after three fires.
- fetch_ready_i=0 for 3 cycles at pc 0x8000_0004, with redirect_valid_i to 0x8000_0100 in stall cycle 2 -> pc holds 0x8000_0004 until fire, then next pc 0x8000_0100.
- Same cycle: redirect to 0x100 and trap to 0x200, no outstanding request -> next pc 0x200; pending trap then redirect during a stall -> 0x200 applied.
- RESET_VECTOR=0xFFFF_FFF8, free-run -> 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- halt_i during an outstanding request -> HALTED one cycle after fire, valid=0; trap to 0x300 -> RUN, fetch_pc_o=0x300.
- With macro: redirect to 0x8000_0102 -> misalign_o=1 for one cycle, misalign_addr_o=0x8000_0102, pc sequential. Without macro -> pc 0x8000_0100.
